// File: rtl/pipe_pkg.sv
// Shared definitions for the parametrised inter-stage pipeline register:
// control-field layout, default widths and the per-stage action encoding.
package pipe_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int DATA_W_DEF = 165;

  // Bit offsets of the fields inside the packed control vector
  localparam int CTRL_WREN       = 0;
  localparam int CTRL_DMEM_R     = 1;
  localparam int CTRL_DMEM_W     = 2;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_JUMP       = 4;
  localparam int CTRL_MUX_A      = 5;
  localparam int CTRL_MUX_B      = 6;
  localparam int CTRL_WB_SEL_LSB = 7;
  localparam int CTRL_WB_SEL_W   = 2;
  localparam int CTRL_ALU_OP_LSB = 9;
  localparam int CTRL_ALU_OP_W   = 4;
  localparam int CTRL_FUN3_LSB   = 13;
  localparam int CTRL_FUN3_W     = 3;

  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = {CTRL_W_DEF{1'b0}};

  typedef enum logic [1:0] {
    STAGE_LOAD = 2'd0,
    STAGE_HOLD = 2'd1,
    STAGE_KILL = 2'd2,
    STAGE_NOP  = 2'd3
  } stage_op_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream bundle of the pipeline register: slot payload,
// pipeline control inputs and the last-stage outputs.
interface pipe_stage_reg_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              busywait;
  logic              flush;
  logic              bubble;
  logic              in_ready;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, busywait, flush, bubble,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, busywait, flush, bubble,
    output in_ready, out_valid, out_ctrl, out_data
  );

endinterface

// File: rtl/pipe_stage_cell.sv
// One register stage: valid bit, control vector and data payload, with
// kill > hold > nop > load priority. Invalid stages always carry ctrl=0.
module pipe_stage_cell
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit CLEAR_DATA = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              hold,
  input  logic              kill,
  input  logic              nop,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              nxt_valid,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  logic              valid_r;
  logic [CTRL_W-1:0] ctrl_r;
  logic [DATA_W-1:0] data_r;
  logic              valid_nxt_s;
  logic [CTRL_W-1:0] ctrl_nxt_s;
  logic [DATA_W-1:0] data_nxt_s;
  stage_op_e         op_s;

  // Resolve the action for this edge; kill wins so a flush survives a stall
  always_comb begin
    if (kill) begin
      op_s = STAGE_KILL;
    end else if (hold) begin
      op_s = STAGE_HOLD;
    end else if (nop) begin
      op_s = STAGE_NOP;
    end else if (load) begin
      op_s = STAGE_LOAD;
    end else begin
      op_s = STAGE_HOLD;
    end
  end

  // Next-state contents for the selected action
  always_comb begin
    valid_nxt_s = valid_r;
    ctrl_nxt_s  = ctrl_r;
    data_nxt_s  = data_r;
    case (op_s)
      STAGE_LOAD: begin
        valid_nxt_s = d_valid;
        ctrl_nxt_s  = d_valid ? d_ctrl : {CTRL_W{1'b0}};
        data_nxt_s  = d_data;
      end
      STAGE_KILL: begin
        valid_nxt_s = 1'b0;
        ctrl_nxt_s  = {CTRL_W{1'b0}};
        if (CLEAR_DATA) begin
          data_nxt_s = {DATA_W{1'b0}};
        end else begin
          data_nxt_s = data_r;
        end
      end
      STAGE_NOP: begin
        valid_nxt_s = 1'b0;
        ctrl_nxt_s  = {CTRL_W{1'b0}};
      end
      STAGE_HOLD: begin
        valid_nxt_s = valid_r;
      end
      default: begin
        valid_nxt_s = valid_r;
      end
    endcase
  end

  // Stage storage with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_r <= 1'b0;
      ctrl_r  <= {CTRL_W{1'b0}};
      data_r  <= {DATA_W{1'b0}};
    end else begin
      valid_r <= valid_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
      data_r  <= data_nxt_s;
    end
  end

  assign nxt_valid = valid_nxt_s;
  assign q_valid   = valid_r;
  assign q_ctrl    = ctrl_r;
  assign q_data    = data_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised DEPTH-stage pipeline register with stall, flush of the
// youngest stages, bubble insertion, occupancy and saturating counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W      = CTRL_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 1,
  parameter int FLUSH_DEPTH = 1,
  parameter bit CLEAR_DATA  = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_stage_reg_if.slave  bus,
  output logic [2:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DEPTH-1:0]  q_valid_s;
  logic [DEPTH-1:0]  nxt_valid_s;
  logic [CTRL_W-1:0] q_ctrl_s [DEPTH];
  logic [DATA_W-1:0] q_data_s [DEPTH];
  logic [2:0]        occ_nxt_s;
  logic [2:0]        occupancy_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic [CNT_W-1:0]  flush_cnt_r;

  // Stage 0 takes the upstream slot; every older stage takes its younger neighbour
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic              d_valid_s;
    logic [CTRL_W-1:0] d_ctrl_s;
    logic [DATA_W-1:0] d_data_s;

    if (i == 0) begin : g_head
      assign d_valid_s = bus.in_valid;
      assign d_ctrl_s  = bus.in_ctrl;
      assign d_data_s  = bus.in_data;
    end else begin : g_body
      assign d_valid_s = q_valid_s[i-1];
      assign d_ctrl_s  = q_ctrl_s[i-1];
      assign d_data_s  = q_data_s[i-1];
    end

    pipe_stage_cell #(
      .CTRL_W    (CTRL_W),
      .DATA_W    (DATA_W),
      .CLEAR_DATA(CLEAR_DATA)
    ) u_cell (
      .clk      (clk),
      .reset    (reset),
      .load     (!bus.busywait),
      .hold     (bus.busywait),
      .kill     (bus.flush && (i < FLUSH_DEPTH)),
      .nop      (bus.bubble && (i == 0)),
      .d_valid  (d_valid_s),
      .d_ctrl   (d_ctrl_s),
      .d_data   (d_data_s),
      .nxt_valid(nxt_valid_s[i]),
      .q_valid  (q_valid_s[i]),
      .q_ctrl   (q_ctrl_s[i]),
      .q_data   (q_data_s[i])
    );
  end

  // Popcount of the valid bits the stages will hold after this edge
  always_comb begin
    occ_nxt_s = 3'd0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt_s = occ_nxt_s + {2'b00, nxt_valid_s[i]};
    end
  end

  // Occupancy and saturating stall/flush counters; stall only counts with content held
  always_ff @(posedge clk) begin
    if (!reset) begin
      occupancy_r <= 3'd0;
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      occupancy_r <= occ_nxt_s;
      if (bus.busywait && (occupancy_r != 3'd0) && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (bus.flush && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + CNT_ONE;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bus.in_ready  = !bus.busywait && !bus.bubble;
  assign bus.out_valid = q_valid_s[DEPTH-1];
  assign bus.out_ctrl  = q_ctrl_s[DEPTH-1];
  assign bus.out_data  = q_data_s[DEPTH-1];
  assign occupancy     = occupancy_r;
  assign stall_cnt     = stall_cnt_r;
  assign flush_cnt     = flush_cnt_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg (DEPTH=2, FLUSH_DEPTH=1, CLEAR_DATA=1,
// CNT_W=4): directed slots push expected outputs, a negedge monitor pops them.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW   = 16;
  localparam int DW   = 32;
  localparam int CNTW = 4;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [2:0]      occupancy;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;
  int              checks = 0;
  int              failures = 0;
  bit              mon_en = 1'b0;
  exp_t            exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

  pipe_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .DEPTH(2), .FLUSH_DEPTH(1),
    .CLEAR_DATA(1'b1), .CNT_W(CNTW)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    bus.in_valid = v;
    bus.in_ctrl  = c;
    bus.in_data  = d;
  endtask

  task automatic expect_out(input logic [CW-1:0] c, input logic [DW-1:0] d);
    exp_t e;
    e.ctrl = c;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // A valid last stage is consumed on every edge without busywait
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (bus.out_valid === 1'b1) begin
        if (bus.busywait === 1'b0) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out actual=%0h required=none", bus.out_ctrl);
          end else begin
            e = exp_q.pop_front();
            chk("out_ctrl", {48'd0, bus.out_ctrl}, {48'd0, e.ctrl});
            chk("out_data", {32'd0, bus.out_data}, {32'd0, e.data});
          end
        end
      end else begin
        chk("idle_ctrl_zero", {48'd0, bus.out_ctrl}, 64'd0);
      end
    end
  end

  initial begin
    drive(1'b0, 16'h0000, 32'h0);
    bus.busywait = 1'b0;
    bus.flush    = 1'b0;
    bus.bubble   = 1'b0;
    reset = 1'b0;
    repeat (2) step();
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_ctrl", {48'd0, bus.out_ctrl}, 64'd0);
    chk("rst_out_data", {32'd0, bus.out_data}, 64'd0);
    chk("rst_occupancy", {61'd0, occupancy}, 64'd0);
    chk("rst_stall_cnt", {60'd0, stall_cnt}, 64'd0);
    chk("rst_flush_cnt", {60'd0, flush_cnt}, 64'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    #1;
    chk("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);

    // Normal advance, two-cycle latency
    drive(1'b1, 16'h00A5, 32'h100); expect_out(16'h00A5, 32'h100); step();
    chk("occ_one", {61'd0, occupancy}, 64'd1);
    drive(1'b1, 16'h0123, 32'h104); expect_out(16'h0123, 32'h104); step();
    chk("occ_two", {61'd0, occupancy}, 64'd2);
    chk("lat_out_valid", {63'd0, bus.out_valid}, 64'd1);

    // Stall holds the last stage for three cycles
    drive(1'b0, 16'hFFFF, 32'hBAD);
    bus.busywait = 1'b1;
    #1;
    chk("in_ready_stall", {63'd0, bus.in_ready}, 64'd0);
    repeat (3) begin
      step();
      chk("stall_hold_ctrl", {48'd0, bus.out_ctrl}, 64'h00A5);
      chk("stall_hold_data", {32'd0, bus.out_data}, 64'h100);
    end
    chk("stall_cnt_3", {60'd0, stall_cnt}, 64'd3);
    chk("stall_occ", {61'd0, occupancy}, 64'd2);
    bus.busywait = 1'b0;
    step();

    // Flush during a stall: stage 0 killed and zeroed, stage 1 held
    drive(1'b1, 16'h0F0F, 32'h200); expect_out(16'h0F0F, 32'h200); step();
    drive(1'b1, 16'h3C3C, 32'h204); step();
    drive(1'b1, 16'hFFFF, 32'hDEAD);
    bus.flush    = 1'b1;
    bus.busywait = 1'b1;
    step();
    chk("flush_cnt_1", {60'd0, flush_cnt}, 64'd1);
    chk("flush_stall_cnt", {60'd0, stall_cnt}, 64'd4);
    chk("flush_occ", {61'd0, occupancy}, 64'd1);
    chk("flush_hold_ctrl", {48'd0, bus.out_ctrl}, 64'h0F0F);
    bus.flush    = 1'b0;
    bus.busywait = 1'b0;
    drive(1'b0, 16'h0000, 32'h0);
    step();
    chk("flushed_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flushed_data_zero", {32'd0, bus.out_data}, 64'd0);
    chk("flushed_occ", {61'd0, occupancy}, 64'd0);

    // Bubble inserts a NOP while upstream holds its slot
    drive(1'b1, 16'h0A0A, 32'h300); expect_out(16'h0A0A, 32'h300); step();
    drive(1'b1, 16'h5555, 32'h304); expect_out(16'h5555, 32'h304);
    bus.bubble = 1'b1;
    #1;
    chk("in_ready_bubble", {63'd0, bus.in_ready}, 64'd0);
    step();
    chk("bubble_occ", {61'd0, occupancy}, 64'd1);
    bus.bubble = 1'b0;
    step();
    chk("bubble_gap_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("bubble_gap_ctrl", {48'd0, bus.out_ctrl}, 64'd0);
    drive(1'b0, 16'h0000, 32'h0);
    step();

    // Long stall saturates the 4-bit stall counter at 15
    drive(1'b1, 16'h1111, 32'h400); expect_out(16'h1111, 32'h400); step();
    drive(1'b0, 16'h0000, 32'h0);
    bus.busywait = 1'b1;
    repeat (11) step();
    chk("stall_sat_reach", {60'd0, stall_cnt}, 64'd15);
    repeat (9) step();
    chk("stall_sat_hold", {60'd0, stall_cnt}, 64'd15);
    bus.busywait = 1'b0;
    step();

    // Reset in the middle of a stall with both stages valid
    drive(1'b1, 16'h7777, 32'h500); step();
    drive(1'b1, 16'h8888, 32'h504); step();
    drive(1'b0, 16'h0000, 32'h0);
    bus.busywait = 1'b1;
    repeat (2) step();
    chk("pre_rst_occ", {61'd0, occupancy}, 64'd2);
    reset = 1'b0;
    step();
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_ctrl", {48'd0, bus.out_ctrl}, 64'd0);
    chk("mid_rst_data", {32'd0, bus.out_data}, 64'd0);
    chk("mid_rst_occ", {61'd0, occupancy}, 64'd0);
    chk("mid_rst_stall", {60'd0, stall_cnt}, 64'd0);
    chk("mid_rst_flush", {60'd0, flush_cnt}, 64'd0);
    reset = 1'b1;
    bus.busywait = 1'b0;

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
